// File: rtl/gf32_mont_convert.sv
// gf32_mont_convert: bit-serial conversion into (x^M) and out of (x^-M) the Montgomery domain of GF(2^M)
module gf32_mont_convert #(
  parameter int         M    = 5,
  parameter logic [M:0] POLY = 6'b100101
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [M-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data
);
  localparam int CW = $clog2(M + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [M-1:0]  w_q, w_d, out_data_q;
  logic          mode_q, out_valid_q, in_ready_q;
  logic [M:0]    t0, t1;
  // mode 0 multiplies by x and reduces; mode 1 makes w divisible by x, then divides
  always_comb begin
    t0  = {w_q, 1'b0} ^ (w_q[M-1] ? POLY : '0);
    t1  = {1'b0, w_q} ^ (w_q[0] ? POLY : '0);
    w_d = mode_q ? t1[M:1] : t0[M-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          w_q        <= in_data;
          mode_q     <= in_mode;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          w_q   <= w_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(M - 1)) begin
            out_data_q  <= w_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_gf32_mont_convert.sv
// tb_gf32_mont_convert: directed vectors plus a polynomial-arithmetic scoreboard checked every cycle
module tb_gf32_mont_convert;
  localparam int M = 5;
  localparam logic [5:0] POLY = 6'b100101;
  logic clk, rst, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [4:0] in_data, out_data;
  int total, bad, cyc, acc_cyc;
  logic [4:0] pend[$];
  logic [4:0] last_out, r0, r1;
  int lat;

  gf32_mont_convert #(.M(M), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // a * x^5 as a full carry-less product, reduced by long division
  function automatic logic [4:0] to_mont(input logic [4:0] a);
    logic [9:0] p;
    p = {a, 5'b0};
    for (int i = 9; i >= 5; i--) if (p[i]) p ^= 10'(POLY) << (i - 5);
    return p[4:0];
  endfunction

  // a * x^-5: the unique b whose forward image is a
  function automatic logic [4:0] from_mont(input logic [4:0] a);
    for (int b = 0; b < 32; b++) if (to_mont(5'(b)) == a) return 5'(b);
    return 5'h0;
  endfunction

  function automatic logic [4:0] model(input logic [4:0] a, input logic m);
    return m ? from_mont(a) : to_mont(a);
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      last_out = 0;
    end else begin
      if (pend.size() > 0 && cyc >= acc_cyc + M && out_ready) void'(pend.pop_front());
      else if (pend.size() == 0 && in_valid) begin
        pend.push_back(model(in_data, in_mode));
        acc_cyc = cyc + 1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic ev;
      ev = pend.size() > 0 && cyc >= acc_cyc + M;
      chk("out_valid", 5'(out_valid), 5'(ev));
      chk("in_ready", 5'(in_ready), 5'(pend.size() == 0));
      chk("out_data", out_data, ev ? pend[0] : last_out);
      if (ev) last_out = pend[0];
    end
  end

  task automatic run(input logic [4:0] d, input logic m, input int bp,
                     output logic [4:0] r, output int l);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin total++; bad++; $display("FAIL in_ready timeout: got 0 expected 1"); end
    in_valid = 1; in_data = d; in_mode = m;
    @(posedge clk); #1;
    in_data = ~d; in_mode = ~m;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin total++; bad++; $display("FAIL out_valid timeout: got 0 expected 1"); end
    l = n;
    repeat (bp) @(negedge clk);
    r = out_data;
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  logic [4:0] vd[8] = '{5'h01, 5'h02, 5'h1F, 5'h00, 5'h01, 5'h05, 5'h0A, 5'h00};
  logic       vm[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic [4:0] ve[8] = '{5'h05, 5'h0A, 5'h0C, 5'h00, 5'h17, 5'h01, 5'h02, 5'h00};

  initial begin
    total = 0; bad = 0; cyc = 0; acc_cyc = 0;
    rst = 1; in_valid = 0; in_mode = 0; in_data = 0; out_ready = 0;
    #1;
    chk("reset out_valid", 5'(out_valid), 5'h0);
    chk("reset in_ready", 5'(in_ready), 5'h1);
    chk("reset out_data", out_data, 5'h0);
    chk("model 01 m0", model(5'h01, 0), 5'h05);
    chk("model 1F m0", model(5'h1F, 0), 5'h0C);
    chk("model 01 m1", model(5'h01, 1), 5'h17);
    chk("model 0A m1", model(5'h0A, 1), 5'h02);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run(vd[i], vm[i], 0, r0, lat);
      chk($sformatf("vec%0d", i), r0, ve[i]);
      chk($sformatf("lat%0d", i), 5'(lat), 5'd5);
    end
    for (int i = 0; i < 32; i++) begin
      run(5'(i), 0, 0, r0, lat);
      run(r0, 1, 0, r1, lat);
      chk($sformatf("fwd%0d", i), r0, model(5'(i), 0));
      chk($sformatf("rt%0d", i), r1, 5'(i));
    end
    run(5'h03, 0, 10, r0, lat);
    chk("backpressure data", r0, 5'h0F);
    chk("post pulse out_valid", 5'(out_valid), 5'h0);
    chk("post pulse in_ready", 5'(in_ready), 5'h1);
    in_valid = 1; in_data = 5'h1F; in_mode = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst out_valid", 5'(out_valid), 5'h0);
    chk("midrst in_ready", 5'(in_ready), 5'h1);
    chk("midrst out_data", out_data, 5'h0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("after rst out_valid", 5'(out_valid), 5'h0);
    run(5'h01, 1, 0, r0, lat);
    chk("after rst conv", r0, 5'h17);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gf32_mont_convert.md
Name: gf32_mont_convert

Overview:
- Sequential bit-serial converter between the standard polynomial basis and the Montgomery domain of GF(2^M), P(x)=x^5+x^2+1, R=x^M.
- The Montgomery multiplier computes A·B·x^-M mod P. This block provides both conversions around it:
  - to-domain: a·x^M mod P.
  - from-domain: a·x^-M mod P.
- Sits at the multiplier's operand and result boundary, with valid/ready handshakes on both sides.
- Processes one field-reduction step per clock.

Parameters:
- M, 5, field degree; operand and result width; number of iteration steps.
- POLY, 6'b100101, field polynomial including the x^M term (M+1 bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept an operand
- in_mode  input  1  0 = into Montgomery (·x^M), 1 = out of Montgomery (·x^-M)
- in_data  input  M  operand, polynomial basis, bit i = coefficient of x^i
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  M  converted result

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, state=IDLE, step counter=0, working register=0.
- Reset is asynchronous and aborts any conversion in progress. No partial result is ever presented.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load the working register from in_data, latch in_mode, clear the counter, go to RUN.
- State RUN:
  - in_ready=0. One step per cycle; counter increments each step.
  - Mode 0 step: t = {w,1'b0}; if t[M]=1 then t ^= POLY; w = t[M-1:0].
  - Mode 1 step: if w[0]=1 then t = {1'b0,w} ^ POLY, else t = {1'b0,w}; w = t[M:1].
  - After exactly M steps, go to DONE, set out_data=w and out_valid=1.
- Latency: handshake accepted at edge k gives out_valid=1 after edge k+M (5 cycles). This is fixed and independent of operand value and mode.
- State DONE:
  - out_valid=1, out_data stable, in_ready=0.
  - On out_valid&out_ready: out_valid=0, return to IDLE (in_ready=1 from the next cycle).
  - If out_ready is held low, the result is held indefinitely.
- No overlap: a new operand is never accepted in the same cycle a result is consumed.
  - Throughput is at most one conversion per M+2 cycles.
- in_data and in_mode are sampled only at acceptance. Changes during RUN or DONE have no effect.
- out_data changes only when entering DONE and keeps its value after consumption until the next result.
- Arithmetic is carry-free (XOR) only.
  - Result is always fully reduced (degree < M).
  - Operand 0 yields 0 in both modes.
  - Mode 1 applied to a mode 0 result returns the original operand, and vice versa.
- Out-of-range conditions do not exist: all 2^M operand values are legal.

Test Plan:
- Reset while idle: out_valid=0, in_ready=1, out_data=0.
- Mode 0 conversions:
  - in_data=0x01 -> out_data=0x05 (x^5 = x^2+1), out_valid exactly 5 cycles after acceptance.
  - in_data=0x02 -> 0x0A.
  - in_data=0x1F -> 0x0C.
  - in_data=0x00 -> 0x00.
- Mode 1 conversions:
  - in_data=0x01 -> 0x17.
  - in_data=0x05 -> 0x01.
  - in_data=0x0A -> 0x02.
- Round trip: all 32 operands through mode 0, then the result through mode 1 -> original value.
  - Also check in_ready=0 and that in_valid is ignored throughout RUN and DONE.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data/out_valid stable.
  - Then pulse out_ready for 1 cycle -> out_valid=0 next cycle, in_ready=1.
- Reset mid-operation: assert rst at step 3 of a mode 0 conversion of 0x1F.
  - Outputs go immediately to reset values; no out_valid pulse.
  - A subsequent 0x01/mode 1 conversion returns 0x17.
